// File: rtl/issue_pkg.sv
// Shared types for the issue scoreboard: register index, control FSM states
// and the default architectural register count.
package issue_pkg;

  localparam int NREG_DEF = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/scoreboard_bits.sv
// Per-register pending-write bits with set/clear ports and lookup taps.
// A set wins over a clear to the same index; flush wipes everything.
module scoreboard_bits
  import issue_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_setEn,
  input  logic [4:0]      i_setIdx,
  input  logic            i_clrEn,
  input  logic [4:0]      i_clrIdx,
  input  logic            i_flush,
  input  logic [4:0]      i_rs1Idx,
  input  logic [4:0]      i_rs2Idx,
  input  logic [4:0]      i_rdIdx,
  input  logic [4:0]      i_wbIdx,
  output logic [NREG-1:0] o_busyVec,
  output logic            o_rs1Busy,
  output logic            o_rs2Busy,
  output logic            o_rdBusy,
  output logic            o_wbBusy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busyNext;
  reg_idx_t        w_setIdx;
  reg_idx_t        w_clrIdx;

  assign w_setIdx = i_setIdx;
  assign w_clrIdx = i_clrIdx;

  // Clear first, then set, so a new writer to the retiring register keeps it busy.
  always_comb begin
    w_busyNext = r_busy;
    if (i_clrEn) w_busyNext[w_clrIdx] = 1'b0;
    if (i_setEn && (w_setIdx != '0)) w_busyNext[w_setIdx] = 1'b1;
    if (i_flush) w_busyNext = '0;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busyNext;
  end

  assign o_busyVec = r_busy;
  assign o_rs1Busy = (i_rs1Idx != 5'd0) && r_busy[i_rs1Idx];
  assign o_rs2Busy = (i_rs2Idx != 5'd0) && r_busy[i_rs2Idx];
  assign o_rdBusy  = (i_rdIdx  != 5'd0) && r_busy[i_rdIdx];
  assign o_wbBusy  = (i_wbIdx  != 5'd0) && r_busy[i_wbIdx];

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Define WB_BYPASS_EN to let a writeback release a dependent in the same cycle.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NREG         = NREG_DEF,
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [4:0]         rs1_ind,
  input  logic               rs1_used,
  input  logic [4:0]         rs2_ind,
  input  logic               rs2_used,
  input  logic [4:0]         rd_ind,
  input  logic               rd_wen,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               flush,
  input  logic               drain_req,
  output logic               drain_done,
  output logic [NREG-1:0]    busy_vec,
  output logic [3:0]         inflight,
  output logic               err,
  output logic [STALL_W-1:0] stall_cnt
);

  ctrl_state_e        r_state;
  logic               r_drainDone;
  logic [3:0]         r_inflight;
  logic               r_err;
  logic [STALL_W-1:0] r_stallCnt;

  logic       w_rs1Busy, w_rs2Busy, w_rdBusy, w_wbBusy;
  logic       w_wbHit, w_hazard, w_issue, w_wr, w_stall;
  logic [3:0] w_effInflight;
  logic [3:0] w_inflightNext;

  scoreboard_bits #(.NREG(NREG)) u_bits (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_setEn   (w_wr),
    .i_setIdx  (rd_ind),
    .i_clrEn   (w_wbHit),
    .i_clrIdx  (wb_rd),
    .i_flush   (flush),
    .i_rs1Idx  (rs1_ind),
    .i_rs2Idx  (rs2_ind),
    .i_rdIdx   (rd_ind),
    .i_wbIdx   (wb_rd),
    .o_busyVec (busy_vec),
    .o_rs1Busy (w_rs1Busy),
    .o_rs2Busy (w_rs2Busy),
    .o_rdBusy  (w_rdBusy),
    .o_wbBusy  (w_wbBusy)
  );

  assign w_wbHit = wb_valid && !flush && w_wbBusy;

`ifdef WB_BYPASS_EN
  // A register retiring this cycle no longer blocks, and frees its inflight slot early.
  assign w_hazard = (rs1_used && w_rs1Busy && !(w_wbHit && (wb_rd == rs1_ind)))
                  | (rs2_used && w_rs2Busy && !(w_wbHit && (wb_rd == rs2_ind)))
                  | (rd_wen   && w_rdBusy  && !(w_wbHit && (wb_rd == rd_ind)));
  assign w_effInflight = r_inflight - {3'd0, w_wbHit};
`else
  assign w_hazard = (rs1_used && w_rs1Busy)
                  | (rs2_used && w_rs2Busy)
                  | (rd_wen   && w_rdBusy);
  assign w_effInflight = r_inflight;
`endif

  assign dec_ready = (r_state == RUN) && !flush && !w_hazard
                   && (w_effInflight < 4'(MAX_INFLIGHT));
  assign w_issue   = dec_valid && dec_ready;
  assign w_wr      = w_issue && rd_wen && (rd_ind != 5'd0);
  assign w_stall   = dec_valid && !dec_ready;

  always_comb begin
    w_inflightNext = r_inflight;
    if (flush)                 w_inflightNext = 4'd0;
    else if (w_wr && !w_wbHit) w_inflightNext = r_inflight + 4'd1;
    else if (!w_wr && w_wbHit) w_inflightNext = r_inflight - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= 4'd0;
    else        r_inflight <= w_inflightNext;
  end

  // Any writeback that finds nothing pending is a protocol error; it latches until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_err <= 1'b0;
    else if (wb_valid && !flush && !w_wbBusy) r_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_stallCnt <= '0;
    else if (w_stall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
  end

  // DRAIN looks at the post-update count so the last writeback halts on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drainDone <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (drain_req) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!drain_req) begin
            r_state <= RUN;
          end else if (w_inflightNext == 4'd0) begin
            r_state     <= HALTED;
            r_drainDone <= 1'b1;
          end
        end
        HALTED: begin
          if (!drain_req) begin
            r_state     <= RUN;
            r_drainDone <= 1'b0;
          end
        end
        default: begin
          r_state     <= RUN;
          r_drainDone <= 1'b0;
        end
      endcase
    end
  end

  assign drain_done = r_drainDone;
  assign inflight   = r_inflight;
  assign err        = r_err;
  assign stall_cnt  = r_stallCnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: vector table plus hand sequences for
// flush, drain, async reset and stall-counter saturation.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [4:0]  rs1_ind = '0;
  logic        rs1_used = 1'b0;
  logic [4:0]  rs2_ind = '0;
  logic        rs2_used = 1'b0;
  logic [4:0]  rd_ind = '0;
  logic        rd_wen = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic        drain_req = 1'b0;
  logic        drain_done;
  logic [31:0] busy_vec;
  logic [3:0]  inflight;
  logic        err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  issue_scoreboard #(.NREG(32), .MAX_INFLIGHT(4), .STALL_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .rs1_ind    (rs1_ind),
    .rs1_used   (rs1_used),
    .rs2_ind    (rs2_ind),
    .rs2_used   (rs2_used),
    .rd_ind     (rd_ind),
    .rd_wen     (rd_wen),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .busy_vec   (busy_vec),
    .inflight   (inflight),
    .err        (err),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  r1;
    logic        u1;
    logic [4:0]  rd;
    logic        wen;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        eRdy;
    logic [31:0] eBusy;
    logic [3:0]  eInfl;
    logic        eErr;
    logic [15:0] eStall;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkVec(logic dv, logic [4:0] r1, logic u1, logic [4:0] rd, logic wen,
                                 logic wbv, logic [4:0] wbrd, logic eRdy, logic [31:0] eBusy,
                                 logic [3:0] eInfl, logic eErr, logic [15:0] eStall);
    vec_t v;
    v.dv = dv; v.r1 = r1; v.u1 = u1; v.rd = rd; v.wen = wen; v.wbv = wbv; v.wbrd = wbrd;
    v.eRdy = eRdy; v.eBusy = eBusy; v.eInfl = eInfl; v.eErr = eErr; v.eStall = eStall;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    dec_valid = 1'b0; rs1_ind = '0; rs1_used = 1'b0; rs2_ind = '0; rs2_used = 1'b0;
    rd_ind = '0; rd_wen = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    dec_valid = v.dv; rs1_ind = v.r1; rs1_used = v.u1;
    rd_ind = v.rd; rd_wen = v.wen; wb_valid = v.wbv; wb_rd = v.wbrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    drain_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issueWrite(input logic [4:0] idx);
    @(negedge clk);
    clearInputs();
    dec_valid = 1'b1; rd_ind = idx; rd_wen = 1'b1;
    tick();
  endtask

  initial begin
    // Fields: dv r1 u1 rd wen wbv wbrd | rdy busy infl err stall
    vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h0,     0, 0, 0);
    vecs[1]  = mkVec(1, 0, 1, 5, 1, 0, 0, 1, 32'h20,    1, 0, 0);
    vecs[2]  = mkVec(1, 5, 1, 6, 1, 0, 0, 0, 32'h20,    1, 0, 1);
`ifdef WB_BYPASS_EN
    vecs[3]  = mkVec(1, 5, 1, 6, 1, 1, 5, 1, 32'h40,    1, 0, 1);
    vecs[4]  = mkVec(1, 5, 1, 6, 1, 0, 0, 0, 32'h40,    1, 0, 2);
`else
    vecs[3]  = mkVec(1, 5, 1, 6, 1, 1, 5, 0, 32'h0,     0, 0, 2);
    vecs[4]  = mkVec(1, 5, 1, 6, 1, 0, 0, 1, 32'h40,    1, 0, 2);
`endif
    vecs[5]  = mkVec(0, 0, 0, 0, 0, 1, 6, 1, 32'h0,     0, 0, 2);
    vecs[6]  = mkVec(1, 0, 0, 1, 1, 0, 0, 1, 32'h2,     1, 0, 2);
    vecs[7]  = mkVec(1, 0, 0, 2, 1, 0, 0, 1, 32'h6,     2, 0, 2);
    vecs[8]  = mkVec(1, 0, 0, 3, 1, 0, 0, 1, 32'hE,     3, 0, 2);
    vecs[9]  = mkVec(1, 0, 0, 4, 1, 0, 0, 1, 32'h1E,    4, 0, 2);
    vecs[10] = mkVec(1, 0, 0, 8, 1, 0, 0, 0, 32'h1E,    4, 0, 3);
`ifdef WB_BYPASS_EN
    vecs[11] = mkVec(1, 0, 0, 8, 1, 1, 2, 1, 32'h11A,   4, 0, 3);
    vecs[12] = mkVec(1, 0, 0, 8, 1, 0, 0, 0, 32'h11A,   4, 0, 4);
    vecs[13] = mkVec(0, 0, 0, 0, 0, 1, 7, 0, 32'h11A,   4, 1, 4);
    vecs[14] = mkVec(0, 0, 0, 0, 0, 1, 1, 1, 32'h118,   3, 1, 4);
    vecs[15] = mkVec(1, 0, 0, 3, 1, 1, 3, 1, 32'h118,   3, 1, 4);
`else
    vecs[11] = mkVec(1, 0, 0, 8, 1, 1, 2, 0, 32'h1A,    3, 0, 4);
    vecs[12] = mkVec(1, 0, 0, 8, 1, 0, 0, 1, 32'h11A,   4, 0, 4);
    vecs[13] = mkVec(0, 0, 0, 0, 0, 1, 7, 0, 32'h11A,   4, 1, 4);
    vecs[14] = mkVec(0, 0, 0, 0, 0, 1, 1, 0, 32'h118,   3, 1, 4);
    vecs[15] = mkVec(1, 0, 0, 3, 1, 1, 3, 0, 32'h110,   2, 1, 5);
`endif

    doReset();
    #1;
    checkOutput("reset_busy", busy_vec, 32'h0);
    checkOutput("reset_inflight", 32'(inflight), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_done", 32'(drain_done), 32'h0);
    checkOutput("reset_stall", 32'(stall_cnt), 32'h0);
    checkOutput("reset_ready", 32'(dec_ready), 32'h1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_ready", i), 32'(dec_ready), 32'(vecs[i].eRdy));
      tick();
      checkOutput($sformatf("v%0d_busy", i), busy_vec, vecs[i].eBusy);
      checkOutput($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].eInfl));
      checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].eErr));
      checkOutput($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(vecs[i].eStall));
    end

    // Asynchronous reset lands without waiting for a clock edge.
    @(negedge clk);
    clearInputs();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", busy_vec, 32'h0);
    checkOutput("async_inflight", 32'(inflight), 32'h0);
    checkOutput("async_err", 32'(err), 32'h0);
    checkOutput("async_stall", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flush with four writers outstanding and a simultaneous writeback.
    for (int i = 1; i <= 4; i++) issueWrite(5'(i));
    checkOutput("flush_pre_busy", busy_vec, 32'h1E);
    checkOutput("flush_pre_inflight", 32'(inflight), 32'h4);
    @(negedge clk);
    clearInputs();
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd2;
    #1;
    checkOutput("flush_ready_low", 32'(dec_ready), 32'h0);
    tick();
    checkOutput("flush_busy", busy_vec, 32'h0);
    checkOutput("flush_inflight", 32'(inflight), 32'h0);
    checkOutput("flush_err", 32'(err), 32'h0);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("flush_ready_after", 32'(dec_ready), 32'h1);

    // Drain with two writers in flight.
    issueWrite(5'd1);
    issueWrite(5'd2);
    @(negedge clk);
    clearInputs();
    drain_req = 1'b1;
    tick();
    checkOutput("drain_done_early", 32'(drain_done), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("drain_ready_low", 32'(dec_ready), 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd1;
    tick();
    checkOutput("drain_inflight1", 32'(inflight), 32'h1);
    checkOutput("drain_done_mid", 32'(drain_done), 32'h0);
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd2;
    tick();
    checkOutput("drain_inflight0", 32'(inflight), 32'h0);
    checkOutput("drain_done_set", 32'(drain_done), 32'h1);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("halted_ready_low", 32'(dec_ready), 32'h0);
    drain_req = 1'b0;
    tick();
    checkOutput("run_done_clear", 32'(drain_done), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("run_ready", 32'(dec_ready), 32'h1);

    // Dropping drain_req before HALTED returns straight to RUN.
    issueWrite(5'd9);
    @(negedge clk);
    clearInputs();
    drain_req = 1'b1;
    tick();
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    checkOutput("abort_ready_low", 32'(dec_ready), 32'h0);
    tick();
    checkOutput("abort_done", 32'(drain_done), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("abort_ready_run", 32'(dec_ready), 32'h1);
    checkOutput("abort_busy", busy_vec, 32'h200);

    // Saturate the stall counter behind a RAW hazard on x5.
    doReset();
    issueWrite(5'd5);
    @(negedge clk);
    clearInputs();
    dec_valid = 1'b1; rs1_ind = 5'd5; rs1_used = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("stall_100", 32'(stall_cnt), 32'd100);
    repeat (65440) @(posedge clk);
    #1;
    checkOutput("stall_sat", 32'(stall_cnt), 32'hFFFF);
    checkOutput("stall_ready", 32'(dec_ready), 32'h0);

    @(negedge clk);
    clearInputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
